// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array result collector.
//   DefaultN / DefaultOutW : default matrix dimension and element width
//   bank_status_e          : per-bank fill status (empty, filling, full)
//   elem_lsb()             : bit offset of element (i,j) in a flattened N x N matrix
package systolic_pkg;

    localparam int unsigned DefaultN    = 3;
    localparam int unsigned DefaultOutW = 16;

    typedef enum logic [1:0] {
        BankEmpty   = 2'd0,
        BankFilling = 2'd1,
        BankFull    = 2'd2
    } bank_status_e;

    // Element (i,j) lives at [(i*n+j)*w +: w]; row i starts at elem_lsb(i, 0, n, w).
    function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j,
                                             input int unsigned n, input int unsigned w);
        return (i * n + j) * w;
    endfunction

endpackage

// File: rtl/systolic_result_collector_if.sv
// Bundle of the collector's beat input, matrix handshake and drop reporting.
//   valid_in, row_in   : beat stream from the systolic array
//   c_valid, c_ready   : matrix handshake to the consumer
//   c_matrix           : presented N x N matrix
//   overflow           : sticky dropped-beat flag
//   drop_count         : saturating dropped-beat count (only with COLLECTOR_DROP_CNT_EN)
// Modports: master = array/consumer side, slave = collector side.
interface systolic_result_collector_if #(
    parameter int unsigned N     = systolic_pkg::DefaultN,
    parameter int unsigned OUT_W = systolic_pkg::DefaultOutW
);
    logic                   valid_in;
    logic [N*OUT_W-1:0]     row_in;
    logic                   c_valid;
    logic                   c_ready;
    logic [N*N*OUT_W-1:0]   c_matrix;
    logic                   overflow;
`ifdef COLLECTOR_DROP_CNT_EN
    logic [7:0]             drop_count;

    modport master (
        output valid_in, row_in, c_ready,
        input  c_valid, c_matrix, overflow, drop_count
    );

    modport slave (
        input  valid_in, row_in, c_ready,
        output c_valid, c_matrix, overflow, drop_count
    );
`else
    modport master (
        output valid_in, row_in, c_ready,
        input  c_valid, c_matrix, overflow
    );

    modport slave (
        input  valid_in, row_in, c_ready,
        output c_valid, c_matrix, overflow
    );
`endif

endinterface

// File: rtl/collector_bank.sv
// One N x N result bank: row write port plus fill-status register.
//   clk, reset : clock, synchronous active-high reset (clears data and status)
//   we         : write row_data into row row_idx
//   row_idx    : row being written; writing row N-1 marks the bank full
//   row_data   : one row, element j at [j*OUT_W +: OUT_W]
//   rd_ack     : consumer took the matrix; bank returns to empty
//   status     : current fill status
//   data       : stored matrix, element (i,j) at [(i*N+j)*OUT_W +: OUT_W]
module collector_bank
    import systolic_pkg::*;
#(
    parameter int unsigned N     = DefaultN,
    parameter int unsigned OUT_W = DefaultOutW,
    parameter int unsigned RowW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [RowW-1:0]        row_idx,
    input  logic [N*OUT_W-1:0]     row_data,
    input  logic                   rd_ack,
    output bank_status_e           status,
    output logic [N*N*OUT_W-1:0]   data
);

    localparam int unsigned MatW = N * N * OUT_W;
    localparam int unsigned IdxW = $clog2(MatW);

    logic [MatW-1:0] mem_q, mem_d;
    bank_status_e    status_q, status_d;
    logic [IdxW-1:0] row_lsb;

    always_comb begin
        row_lsb = IdxW'(elem_lsb(32'(row_idx), 0, N, OUT_W));
        mem_d   = mem_q;
        if (we) begin
            mem_d[row_lsb +: N*OUT_W] = row_data;
        end
    end

    // The top never writes a full bank and only acks a full one, so the two are exclusive.
    always_comb begin
        status_d = status_q;
        if (we) begin
            status_d = (row_idx == RowW'(N - 1)) ? BankFull : BankFilling;
        end else if (rd_ack) begin
            status_d = BankEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            status_q <= BankEmpty;
        end else begin
            mem_q    <= mem_d;
            status_q <= status_d;
        end
    end

    assign status = status_q;
    assign data   = mem_q;

endmodule

// File: rtl/systolic_result_collector.sv
// Collects the systolic array's row-per-beat results into N x N matrices and presents
// them to a consumer over valid/ready, using two ping-pong banks.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of systolic_result_collector_if (beats in, matrix out,
//                overflow flag, optional drop_count)
// Build option: define COLLECTOR_DROP_CNT_EN to add the 8-bit saturating drop counter.
module systolic_result_collector
    import systolic_pkg::*;
#(
    parameter int unsigned N     = DefaultN,
    parameter int unsigned OUT_W = DefaultOutW
) (
    input  logic                          clk,
    input  logic                          reset,
    systolic_result_collector_if.slave    bus
);

    localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned MatW = N * N * OUT_W;

    logic            wr_sel_q, wr_sel_d;
    logic            rd_sel_q, rd_sel_d;
    logic [RowW-1:0] row_cnt_q, row_cnt_d;
    logic            overflow_q, overflow_d;

    bank_status_e    bank_status [2];
    logic [MatW-1:0] bank_data   [2];
    logic [1:0]      bank_we;
    logic [1:0]      bank_ack;

    logic fill_full, beat_accept, beat_drop, c_valid_int, handshake, last_row;

    // All decisions use the status before the edge: a same-cycle handshake never
    // rescues a beat aimed at a full bank.
    always_comb begin
        fill_full   = (bank_status[wr_sel_q] == BankFull);
        beat_accept = bus.valid_in && !fill_full;
        beat_drop   = bus.valid_in && fill_full;
        c_valid_int = (bank_status[rd_sel_q] == BankFull);
        handshake   = c_valid_int && bus.c_ready;
        last_row    = (row_cnt_q == RowW'(N - 1));
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b]  = beat_accept && (wr_sel_q == 1'(b));
        assign bank_ack[b] = handshake && (rd_sel_q == 1'(b));

        collector_bank #(
            .N     (N),
            .OUT_W (OUT_W),
            .RowW  (RowW)
        ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .we       (bank_we[b]),
            .row_idx  (row_cnt_q),
            .row_data (bus.row_in),
            .rd_ack   (bank_ack[b]),
            .status   (bank_status[b]),
            .data     (bank_data[b])
        );
    end

    always_comb begin
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        row_cnt_d  = row_cnt_q;
        overflow_d = overflow_q;
        if (beat_accept) begin
            if (last_row) begin
                row_cnt_d = '0;
                wr_sel_d  = ~wr_sel_q;
            end else begin
                row_cnt_d = row_cnt_q + 1'b1;
            end
        end
        if (handshake) begin
            rd_sel_d = ~rd_sel_q;
        end
        if (beat_drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            row_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            row_cnt_q  <= row_cnt_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef COLLECTOR_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (beat_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_count = drop_cnt_q;
`endif

    assign bus.c_valid  = c_valid_int;
    assign bus.c_matrix = bank_data[rd_sel_q];
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Scoreboard bench for systolic_result_collector: the stimulus pushes expected matrices,
// a negedge monitor pops and compares on every c_valid && c_ready.
module tb_systolic_result_collector;

    typedef logic [143:0] mat_t;

    localparam logic [47:0] R1 = 48'h0003_0002_0001;
    localparam logic [47:0] R2 = 48'h0006_0005_0004;
    localparam logic [47:0] R3 = 48'h0009_0008_0007;
    localparam logic [47:0] S1 = 48'h0013_0012_0011;
    localparam logic [47:0] S2 = 48'h0016_0015_0014;
    localparam logic [47:0] S3 = 48'h0019_0018_0017;
    localparam logic [47:0] T1 = 48'h0023_0022_0021;
    localparam logic [47:0] T2 = 48'h0026_0025_0024;
    localparam logic [47:0] T3 = 48'h0029_0028_0027;
    localparam logic [47:0] JUNK = 48'hDEAD_BEEF_CAFE;
    localparam logic [47:0] DROP = 48'h00FF_00FF_00FF;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    mat_t sb[$];

    systolic_result_collector_if bus ();

    systolic_result_collector dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic mat_t mk(input logic [47:0] r0, input logic [47:0] r1,
                                input logic [47:0] r2);
        return {r2, r1, r0};
    endfunction

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [47:0] row);
        bus.valid_in = 1'b1;
        bus.row_in   = row;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (!reset && bus.c_valid && bus.c_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL monitor_unexpected: got %0h expected no matrix", bus.c_matrix);
            end else begin
                mat_t exp;
                exp = sb.pop_front();
                if (bus.c_matrix !== exp) begin
                    errors++;
                    $display("FAIL monitor_matrix: got %0h expected %0h", bus.c_matrix, exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] pattern;
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        bus.row_in   = '0;
        bus.c_ready  = 1'b0;
        do_reset();

        // Reset state
        check("rst_c_valid", bus.c_valid, 0);
        check("rst_c_matrix", bus.c_matrix, 0);
        check("rst_overflow", bus.overflow, 0);
`ifdef COLLECTOR_DROP_CNT_EN
        check("rst_drop_count", bus.drop_count, 0);
`endif

        // Consecutive beats, consumer ready
        bus.c_ready = 1'b1;
        sb.push_back(mk(R1, R2, R3));
        send_beat(R1);
        send_beat(R2);
        check("b2b_no_early_valid", bus.c_valid, 0);
        send_beat(R3);
        check("b2b_valid_after_beat3", bus.c_valid, 1);
        check("b2b_elem00", bus.c_matrix[15:0], 16'd1);
        check("b2b_elem22", bus.c_matrix[(2*3+2)*16 +: 16], 16'd9);
        idle(1);
        check("b2b_valid_one_cycle", bus.c_valid, 0);

        // Idle gaps between beats
        sb.push_back(mk(R1, R2, R3));
        send_beat(R1);
        idle(2);
        send_beat(R2);
        idle(2);
        check("gap_no_early_valid", bus.c_valid, 0);
        send_beat(R3);
        check("gap_valid_after_beat3", bus.c_valid, 1);
        idle(1);

        // Both banks full, seventh beat dropped
        bus.c_ready = 1'b0;
        sb.push_back(mk(R1, R2, R3));
        sb.push_back(mk(S1, S2, S3));
        send_beat(R1); send_beat(R2); send_beat(R3);
        send_beat(S1); send_beat(S2); send_beat(S3);
        check("full_c_valid", bus.c_valid, 1);
        check("full_no_overflow_yet", bus.overflow, 0);
        send_beat(DROP);
        check("drop_overflow", bus.overflow, 1);
`ifdef COLLECTOR_DROP_CNT_EN
        check("drop_count_one", bus.drop_count, 1);
`endif
        idle(3);
        check("hold_matrix1", bus.c_matrix, mk(R1, R2, R3));
        check("overflow_sticky", bus.overflow, 1);
        bus.c_ready = 1'b1;
        idle(1);
        check("next_matrix2", bus.c_matrix, mk(S1, S2, S3));
        check("next_valid", bus.c_valid, 1);
        idle(1);
        check("drained_valid", bus.c_valid, 0);

        // Six back-to-back beats with ready held: pulses after beats 3 and 6
        do_reset();
        check("reset_clears_overflow", bus.overflow, 0);
        bus.c_ready = 1'b1;
        sb.push_back(mk(S1, S2, S3));
        sb.push_back(mk(T1, T2, T3));
        pattern = '0;
        send_beat(S1); pattern[0] = bus.c_valid;
        send_beat(S2); pattern[1] = bus.c_valid;
        send_beat(S3); pattern[2] = bus.c_valid;
        send_beat(T1); pattern[3] = bus.c_valid;
        send_beat(T2); pattern[4] = bus.c_valid;
        send_beat(T3); pattern[5] = bus.c_valid;
        check("stream_valid_pattern", pattern, 6'b100100);
        idle(1);
        check("stream_no_overflow", bus.overflow, 0);

        // Reset mid-matrix discards partial rows
        send_beat(JUNK);
        send_beat(JUNK);
        do_reset();
        check("midrst_c_valid", bus.c_valid, 0);
        check("midrst_c_matrix", bus.c_matrix, 0);
        sb.push_back(mk(T1, T2, T3));
        send_beat(T1); send_beat(T2); send_beat(T3);
        check("midrst_fresh_valid", bus.c_valid, 1);
        check("midrst_fresh_matrix", bus.c_matrix, mk(T1, T2, T3));
        idle(1);

        // Saturation under a long overload
        bus.c_ready = 1'b0;
        sb.push_back(mk(R1, R2, R3));
        sb.push_back(mk(T1, T2, T3));
        send_beat(R1); send_beat(R2); send_beat(R3);
        send_beat(T1); send_beat(T2); send_beat(T3);
        for (int i = 0; i < 300; i++) send_beat(DROP);
        check("sat_overflow", bus.overflow, 1);
`ifdef COLLECTOR_DROP_CNT_EN
        check("sat_drop_count", bus.drop_count, 255);
`endif
        check("sat_hold_matrix", bus.c_matrix, mk(R1, R2, R3));
        bus.c_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            idle(1);
        end
        idle(2);
        check("scoreboard_empty", sb.size(), 0);
        check("final_c_valid", bus.c_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_result_collector.md
# systolic_result_collector

Receive-side companion of the 3x3 systolic array `top`. It captures the array's row-per-beat result stream (`valid_out`/`matrix_c_out`) and assembles N beats into one complete N×N result matrix. It presents each finished matrix to the downstream consumer through a valid/ready handshake. Ping-pong banking lets one matrix fill while the previous one waits to be consumed.

## Interface
- `N`, 3: matrix dimension; beats per matrix and elements per beat.
- `OUT_W`, 16: width of one result element.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `valid_in`  in  1: beat strobe; connects to the array's `valid_out`.
- `row_in`  in  N*OUT_W: one row of C; element j at `[j*OUT_W +: OUT_W]`.
- `c_valid`  out  1: a complete matrix is presented.
- `c_ready`  in  1: consumer accepts the presented matrix.
- `c_matrix`  out  N*N*OUT_W: element (i,j) at `[(i*N+j)*OUT_W +: OUT_W]`.
- `overflow`  out  1: sticky; a beat was dropped because both banks were full.
- `drop_count`  out  8: saturating dropped-beat count. Present only with `COLLECTOR_DROP_CNT_EN`.

## Operation
- Two banks, each N*N*OUT_W wide. Each bank has a status of EMPTY, FILLING or FULL.
- `wr_sel` selects the fill bank and `rd_sel` selects the presented bank. Both reset to 0.
- `row_cnt` (0..N-1) indexes the next row of the fill bank.
- Beat accept: `valid_in`=1 and the fill bank is not FULL.
  - `row_in` is written to row `row_cnt` of the fill bank, and `row_cnt` increments.
  - At `row_cnt`=N-1, `row_cnt` wraps to 0, the bank becomes FULL and `wr_sel` toggles.
- `valid_in`=0 is an idle gap. No state changes and the partial matrix is retained. Gaps between beats of one matrix are legal.
- `c_valid` = status[`rd_sel`]==FULL. `c_matrix` = contents of bank `rd_sel`.
- Handshake: `c_valid`&&`c_ready` at an edge transfers the matrix. Bank `rd_sel` becomes EMPTY and `rd_sel` toggles.
- `c_matrix` stays stable while `c_valid`=1 and `c_ready`=0.
- Drop: `valid_in`=1 while the fill bank is FULL (both banks FULL).
  - The beat is discarded, `row_cnt` is unchanged, and `overflow` sets.
- Element values are stored unmodified. There is no arithmetic on data.

## Timing
- Reset values: `c_valid`=0, `c_matrix`=0, `overflow`=0, `drop_count`=0. Both banks are EMPTY and `row_cnt`=0.
- Latency: `c_valid` is high in the cycle after the edge that captures beat N-1 (registered status).
- Back-to-back matrices (3N consecutive beats) with `c_ready` held at 1 cause no drops. `c_valid` pulses one cycle per matrix.
- Final beat into bank X at the same edge as a handshake on bank Y:
  - Both actions take effect.
  - Next cycle `c_valid`=1 with bank X's data, because `rd_sel` now points to X.
- Handshake at the same edge that frees the only FULL bank while a beat arrives:
  - Before the edge, the fill bank is the other (non-FULL) bank, so the beat is accepted.
  - There is no drop.
- Drop check uses the status before the edge. A handshake in the same cycle does not rescue a beat aimed at a FULL fill bank.
- Reset mid-matrix or mid-handshake discards everything; the next `valid_in` beat is row 0.
- `overflow` clears only on reset.
- `drop_count` saturates at 255.

## Configuration
- `COLLECTOR_DROP_CNT_EN` defined: the `drop_count` port and its 8-bit saturating counter exist. The counter increments on every dropped beat.
- Not defined: the port and counter are absent and only the sticky `overflow` flag reports drops.
- Functional behaviour is otherwise identical in both builds.

## Structure
- Shared package `systolic_pkg`:
  - default `N`, `OUT_W`;
  - bank status enum (EMPTY, FILLING, FULL);
  - the element-index helper for `(i*N+j)*OUT_W`.
- One sub-module: `collector_bank`, instantiated twice.
  - It holds the N×N storage, the row write port (`we`, `row_idx`, `row_data`) and its status register.
- The top level holds `wr_sel`, `rd_sel`, `row_cnt`, the drop logic and the output mux.

## Test plan
- Reset, then beats 0x0003_0002_0001, 0x0006_0005_0004, 0x0009_0008_0007 on consecutive cycles with `c_ready`=1 -> `c_valid`=1 for one cycle, the cycle after beat 3. `c_matrix` elements (0,0)..(2,2) = 1..9.
- Same three beats with idle gaps of 2 cycles between them -> identical matrix. `c_valid` rises only after the third beat.
- `c_ready`=0 while 6 beats arrive (two matrices), then a 7th beat of 0x00FF_00FF_00FF -> the 7th beat is dropped.
  - `overflow`=1; with the macro, `drop_count`=1.
  - `c_matrix` stays on matrix 1 until `c_ready` rises. Then matrix 2 is presented the next cycle.
- 6 back-to-back beats with `c_ready`=1 -> two one-cycle `c_valid` pulses, 3 cycles apart, each with the correct data, and `overflow`=0.
- Assert `reset` after 2 beats of a matrix, then send 3 fresh beats -> the matrix contains only the fresh beats and the old rows are gone.
- Hold both banks FULL and send 300 beats (macro defined) -> `drop_count` saturates at 255 and `overflow`=1.
